set_assoc_cache: RTL and testbench
==================================

// Module: set_assoc_cache
// PURPOSE
//  Parametrised 2-way set-associative read cache between the MEM stage and the SRAM controller.
//  - Configurable sets and line width; true per-set LRU replacement.
//  - Read-miss refill FSM; write-through with no write-allocate.
//  - Ready-based stall handshake toward the pipeline.
// PARAMETERS
//  ADDR_W      32  MEM-stage byte address width
//  DATA_W      32  word width
//  SETS        64  sets per way, power of 2; IDX_W = clog2(SETS)
//  LINE_WORDS  2   words per line, power of 2; OFF_W = clog2(LINE_WORDS); SRAM line = DATA_W*LINE_WORDS
//  TAG_W       ADDR_W-2-OFF_W-IDX_W  derived, not overridable
// PORTS
//  clk          in   1                     clock
//  rst          in   1                     async reset, active-high
//  address      in   ADDR_W                byte address; [1:0] ignored; word=[OFF_W+1:2], index=next IDX_W bits, tag=rest
//  wdata        in   DATA_W                store data
//  MEM_R_EN     in   1                     load request, held until ready
//  MEM_W_EN     in   1                     store request, held until ready
//  rdata        out  DATA_W                load data, valid when ready
//  ready        out  1                     request completes this cycle
//  sram_address out  ADDR_W                line-aligned on refill, word address on write
//  sram_wdata   out  DATA_W                write-through data
//  sram_read    out  1                     refill request, held until sram_ready
//  write        out  1                     SRAM write request, held until sram_ready
//  sram_rdata   in   DATA_W*LINE_WORDS     refill line, word 0 in LSBs
//  sram_ready   in   1                     SRAM completes the current request this cycle
// BEHAVIOUR
//  - Reset (async): FSM=IDLE, all valid bits=0, LRU bits=0, ready/sram_read/write=0; data/tag arrays not reset.
//  - Outputs rdata, sram_address and sram_wdata are 0 whenever ready, sram_read and write are all 0.
//  - Hit: valid && tag match in a way; at most one way hits by construction.
//  - FSM states: IDLE, REFILL, WTHRU.
//  - IDLE, read hit:
//    - ready=1 combinationally, 0 wait states.
//    - rdata=hit way word; LRU[index]=other way. Stay IDLE.
//  - IDLE, read miss -> REFILL.
//    - sram_read=1 with sram_address={tag,index,OFF_W+2 zeros} until sram_ready.
//  - REFILL, sram_ready=1:
//    - ready=1 that cycle; rdata=sram_rdata word[word].
//    - At the clock edge, write line+tag into the victim, set valid, LRU[index]=other way; go to IDLE.
//  - Victim: way0 if invalid, else way1 if invalid, else way LRU[index].
//  - IDLE, MEM_W_EN -> WTHRU.
//    - write=1, sram_address=address, sram_wdata=wdata until sram_ready.
//  - WTHRU, sram_ready=1:
//    - ready=1.
//    - On hit, update that word in the hit way and set LRU[index]=other way; on miss, no allocation.
//    - Go to IDLE.
//  - MEM_R_EN && MEM_W_EN together: treated as a write.
//  - Neither enable asserted: IDLE, outputs 0.
//  - Request dropped mid-REFILL/WTHRU: the SRAM transaction still completes (fill/update still happens); ready ignored.
//  - Reset mid-REFILL/WTHRU: state is abandoned immediately and sram_read/write drop in the same cycle.
//  - After ready the requester changes or drops its request; a request held over is served again from IDLE.
// CONFIGURATION
//  CACHE_STATS_EN defined: adds two 32-bit outputs.
//  - hit_count: read hits.
//  - miss_count: refills, counted on the refill-complete cycle.
//  - Both reset to 0, wrap at 2^32, writes not counted.
//  CACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package cache_pkg:
//  - FSM state enum (IDLE/REFILL/WTHRU).
//  - Address-field width/offset function helpers (IDX_W, OFF_W, TAG_W).
//  - Line/tag typedefs.
//  Sub-module cache_way (instantiated twice):
//  - valid/tag/data arrays; combinational lookup (hit, word) by index/tag/word.
//  - Line-fill and word-write ports; async valid clear.
//  Top level holds the FSM, LRU vector, victim select and SRAM mux.
// TESTING
//  1. Reset, then read 0x100: REFILL; sram_read=1, sram_address=0x100; sram_ready after 3 cycles with line {0xBBBB,0xAAAA}.
//     Expect ready=1, rdata=0xAAAA.
//     Then read 0x104: hit, ready same cycle, rdata=0xBBBB.
//  2. Three reads to the same set, tags A, B, C (index 0), then read A:
//     - A fills way0 and B fills way1.
//     - C evicts A (LRU).
//     - A misses again and evicts B.
//  3. Read 0x200 (hit after fill), then write 0x200=0x1234:
//     - write=1, sram_wdata=0x1234, ready on sram_ready.
//     - Next read 0x200 hits with rdata=0x1234.
//  4. Write to uncached 0x300, then read 0x300: expect write-through, then a miss (no allocate).
//  5. Assert rst during REFILL before sram_ready: sram_read=0 immediately; the previous hit line now misses.
//  6. Assert MEM_R_EN and MEM_W_EN together: write path taken.
//     With CACHE_STATS_EN, after tests 1 and 3: hit_count=2, miss_count=2.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way set-associative read cache.
// Optional feature macro used by the top level: CACHE_STATS_EN (hit/miss counters).
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_WTHRU  = 2'd2
    } cache_state_e;

    function automatic int off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Byte address = {tag, index, word, 2'b byte}
    function automatic int tag_w(input int addr_w, input int sets, input int line_words);
        return addr_w - 2 - off_w(line_words) - idx_w(sets);
    endfunction

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 2;

    typedef logic [DEF_DATA_W*DEF_LINE_WORDS-1:0]                     line_t;
    typedef logic [tag_w(DEF_ADDR_W, DEF_SETS, DEF_LINE_WORDS)-1:0] tag_t;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data storage with combinational lookup,
// whole-line fill and single-word update at the looked-up index.
module cache_way
    import cache_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  int SETS       = 64,
    parameter  int LINE_WORDS = 2,
    parameter  int TAG_W      = 23,
    localparam int IDX_W      = idx_w(SETS),
    localparam int OFF_W      = off_w(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [IDX_W-1:0]             index,
    input  logic [TAG_W-1:0]             tag,
    input  logic [OFF_W-1:0]             word,
    output logic                         valid,
    output logic                         hit,
    output logic [DATA_W-1:0]            rdata,
    input  logic                         fill_en,
    input  logic [DATA_W*LINE_WORDS-1:0] fill_line,
    input  logic                         wr_en,
    input  logic [DATA_W-1:0]            wr_data
);

    logic [SETS-1:0]   valid_r;
    logic [TAG_W-1:0]  tag_mem_r  [SETS];
    logic [DATA_W-1:0] data_mem_r [SETS][LINE_WORDS];

    // valid bits are the only reset state; a fill marks the line present
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (fill_en) begin
            valid_r[index] <= 1'b1;
        end
    end

    // tag/data storage: fill takes priority over a word update
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem_r[index] <= tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_mem_r[index][w] <= fill_line[w*DATA_W +: DATA_W];
            end
        end else if (wr_en) begin
            data_mem_r[index][word] <= wr_data;
        end
    end

    // lookup
    always_comb begin
        valid = valid_r[index];
        hit   = valid_r[index] && (tag_mem_r[index] == tag);
        rdata = data_mem_r[index][word];
    end

endmodule

// File: rtl/set_assoc_cache.sv
// 2-way set-associative write-through read cache with LRU replacement and refill FSM.
// Define CACHE_STATS_EN to add hit_count/miss_count outputs.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int SETS       = 64,
    parameter  int LINE_WORDS = 2,
    localparam int OFF_W      = off_w(LINE_WORDS),
    localparam int IDX_W      = idx_w(SETS),
    localparam int TAG_W      = tag_w(ADDR_W, SETS, LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            address,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         MEM_R_EN,
    input  logic                         MEM_W_EN,
    output logic [DATA_W-1:0]            rdata,
    output logic                         ready,
    output logic [ADDR_W-1:0]            sram_address,
    output logic [DATA_W-1:0]            sram_wdata,
    output logic                         sram_read,
    output logic                         write,
    input  logic [DATA_W*LINE_WORDS-1:0] sram_rdata,
    input  logic                         sram_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  hit_count,
    output logic [31:0]                  miss_count
`endif
);

    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = 2 + OFF_W + IDX_W;

    cache_state_e state_r, next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [SETS-1:0]   lru_r;

    logic [ADDR_W-1:0] cur_addr_s;
    logic [IDX_W-1:0]  idx_s;
    logic [TAG_W-1:0]  tag_s;
    logic [OFF_W-1:0]  word_s;

    logic              valid0_s, valid1_s, hit0_s, hit1_s;
    logic [DATA_W-1:0] rd0_s, rd1_s;
    logic              victim_s;
    logic              fill_s, wupd_s, lru_upd_s, lru_val_s, latch_s, hit_evt_s;
    logic [DATA_W-1:0] refill_word_s [LINE_WORDS];

    // Outside IDLE the request may be dropped, so lookups use the latched address
    always_comb begin
        if (state_r == ST_IDLE) begin
            cur_addr_s = address;
        end else begin
            cur_addr_s = addr_r;
        end
        idx_s  = cur_addr_s[IDX_LSB +: IDX_W];
        tag_s  = cur_addr_s[TAG_LSB +: TAG_W];
        word_s = cur_addr_s[2 +: OFF_W];
    end

    cache_way #(
        .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
    ) u_way0 (
        .clk(clk), .rst(rst), .index(idx_s), .tag(tag_s), .word(word_s),
        .valid(valid0_s), .hit(hit0_s), .rdata(rd0_s),
        .fill_en(fill_s && !victim_s), .fill_line(sram_rdata),
        .wr_en(wupd_s && hit0_s), .wr_data(wdata_r)
    );

    cache_way #(
        .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
    ) u_way1 (
        .clk(clk), .rst(rst), .index(idx_s), .tag(tag_s), .word(word_s),
        .valid(valid1_s), .hit(hit1_s), .rdata(rd1_s),
        .fill_en(fill_s && victim_s), .fill_line(sram_rdata),
        .wr_en(wupd_s && hit1_s), .wr_data(wdata_r)
    );

    // victim select and refill line unpacking
    always_comb begin
        if (!valid0_s) begin
            victim_s = 1'b0;
        end else if (!valid1_s) begin
            victim_s = 1'b1;
        end else begin
            victim_s = lru_r[idx_s];
        end
        for (int w = 0; w < LINE_WORDS; w++) begin
            refill_word_s[w] = sram_rdata[w*DATA_W +: DATA_W];
        end
    end

    // FSM next state, handshake outputs and array update strobes
    always_comb begin
        next_state_s = state_r;
        ready        = 1'b0;
        rdata        = '0;
        sram_address = '0;
        sram_wdata   = '0;
        sram_read    = 1'b0;
        write        = 1'b0;
        fill_s       = 1'b0;
        wupd_s       = 1'b0;
        lru_upd_s    = 1'b0;
        lru_val_s    = 1'b0;
        latch_s      = 1'b0;
        hit_evt_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (MEM_W_EN) begin
                    next_state_s = ST_WTHRU;
                    latch_s      = 1'b1;
                end else if (MEM_R_EN) begin
                    if (hit0_s || hit1_s) begin
                        ready     = 1'b1;
                        rdata     = hit0_s ? rd0_s : rd1_s;
                        lru_upd_s = 1'b1;
                        lru_val_s = hit0_s;
                        hit_evt_s = 1'b1;
                    end else begin
                        next_state_s = ST_REFILL;
                        latch_s      = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REFILL: begin
                sram_read    = 1'b1;
                sram_address = {addr_r[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
                if (sram_ready) begin
                    ready        = 1'b1;
                    rdata        = refill_word_s[word_s];
                    fill_s       = 1'b1;
                    lru_upd_s    = 1'b1;
                    lru_val_s    = !victim_s;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_REFILL;
                end
            end
            ST_WTHRU: begin
                write        = 1'b1;
                sram_address = addr_r;
                sram_wdata   = wdata_r;
                if (sram_ready) begin
                    ready        = 1'b1;
                    wupd_s       = 1'b1;
                    lru_upd_s    = hit0_s || hit1_s;
                    lru_val_s    = hit0_s;
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_WTHRU;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // state, request capture and LRU bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= '0;
            wdata_r <= '0;
            lru_r   <= '0;
        end else begin
            state_r <= next_state_s;
            if (latch_s) begin
                addr_r  <= address;
                wdata_r <= wdata;
            end
            if (lru_upd_s) begin
                lru_r[idx_s] <= lru_val_s;
            end
        end
    end

`ifdef CACHE_STATS_EN
    // read-hit and refill counters, wrapping naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else begin
            if (hit_evt_s) begin
                hit_count <= hit_count + 32'd1;
            end
            if (fill_s) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed self-checking bench for set_assoc_cache (default configuration).
module tb_set_assoc_cache;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata;
    logic        MEM_R_EN, MEM_W_EN, ready, sram_read, write, sram_ready;
    line_t       sram_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int vectors     = 0;
    int miscompares = 0;

    set_assoc_cache dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_read(sram_read),
        .write(write), .sram_rdata(sram_rdata), .sram_ready(sram_ready)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_hit(input string t, input logic [31:0] a, input logic [31:0] exp);
        address  = a;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        chk({t, "_ready"}, 64'(ready), 64'h1);
        chk({t, "_rdata"}, 64'(rdata), 64'(exp));
        chk({t, "_no_read"}, 64'(sram_read), 64'h0);
        @(posedge clk); #1;
        MEM_R_EN = 1'b0;
    endtask

    task automatic read_miss(input string t, input logic [31:0] a, input line_t line,
                             input int lat, input logic [31:0] exp);
        address  = a;
        MEM_R_EN = 1'b1;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        chk({t, "_miss_noready"}, 64'(ready), 64'h0);
        @(posedge clk); #1;
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            chk({t, "_sram_read"}, 64'(sram_read), 64'h1);
            chk({t, "_sram_addr"}, 64'(sram_address), 64'({a[31:3], 3'b000}));
            chk({t, "_wait"}, 64'(ready), 64'h0);
            @(posedge clk); #1;
        end
        sram_rdata = line;
        sram_ready = 1'b1;
        @(negedge clk);
        chk({t, "_fill_ready"}, 64'(ready), 64'h1);
        chk({t, "_fill_rdata"}, 64'(rdata), 64'(exp));
        @(posedge clk); #1;
        sram_ready = 1'b0;
        sram_rdata = '0;
        MEM_R_EN   = 1'b0;
    endtask

    task automatic write_op(input string t, input logic [31:0] a, input logic [31:0] d,
                            input logic both);
        address  = a;
        wdata    = d;
        MEM_W_EN = 1'b1;
        MEM_R_EN = both;
        @(negedge clk);
        chk({t, "_idle_noready"}, 64'(ready), 64'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({t, "_write"}, 64'(write), 64'h1);
        chk({t, "_no_read"}, 64'(sram_read), 64'h0);
        chk({t, "_wdata"}, 64'(sram_wdata), 64'(d));
        chk({t, "_addr"}, 64'(sram_address), 64'(a));
        sram_ready = 1'b1;
        #1;
        chk({t, "_ready"}, 64'(ready), 64'h1);
        @(posedge clk); #1;
        sram_ready = 1'b0;
        MEM_W_EN   = 1'b0;
        MEM_R_EN   = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        address    = '0;
        wdata      = '0;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        sram_ready = 1'b0;
        sram_rdata = '0;
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_sram_read", 64'(sram_read), 64'h0);
        chk("rst_write", 64'(write), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_sram_addr", 64'(sram_address), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // first fill and a hit on the other word of the line
        read_miss("t1", 32'h100, {32'h0000BBBB, 32'h0000AAAA}, 3, 32'h0000AAAA);
        read_hit("t1h", 32'h104, 32'h0000BBBB);

        // write-through updates a cached word
        read_miss("t3", 32'h200, {32'h0000DDDD, 32'h0000CCCC}, 1, 32'h0000CCCC);
        write_op("t3w", 32'h200, 32'h00001234, 1'b0);
        read_hit("t3h", 32'h200, 32'h00001234);
`ifdef CACHE_STATS_EN
        chk("stats_hit", 64'(hit_count), 64'd2);
        chk("stats_miss", 64'(miss_count), 64'd2);
`endif
        read_hit("t3h2", 32'h204, 32'h0000DDDD);

        // write miss does not allocate
        write_op("t4w", 32'h300, 32'h00005555, 1'b0);
        read_miss("t4", 32'h300, {32'h00007777, 32'h00006666}, 1, 32'h00006666);
        read_hit("t4h", 32'h104, 32'h0000BBBB);

        // reset during a refill
        address  = 32'h400;
        MEM_R_EN = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_refill", 64'(sram_read), 64'h1);
        rst = 1'b1;
        #1;
        chk("t5_read_drop", 64'(sram_read), 64'h0);
        chk("t5_ready", 64'(ready), 64'h0);
        @(posedge clk); #1;
        rst      = 1'b0;
        MEM_R_EN = 1'b0;
        @(posedge clk); #1;
        read_miss("t5", 32'h104, {32'h0000BBBB, 32'h0000AAAA}, 2, 32'h0000BBBB);

        // both enables: write path
        write_op("t6", 32'h104, 32'h00009999, 1'b1);
        read_hit("t6h", 32'h104, 32'h00009999);
        read_hit("t6h0", 32'h100, 32'h0000AAAA);

        // LRU replacement in set 0: A, B, C evicts A, A evicts B
        read_miss("t2a", 32'h1000, {32'h0000A001, 32'h0000A000}, 1, 32'h0000A000);
        read_miss("t2b", 32'h2000, {32'h0000B001, 32'h0000B000}, 1, 32'h0000B000);
        read_miss("t2c", 32'h3000, {32'h0000C001, 32'h0000C000}, 1, 32'h0000C000);
        read_miss("t2a2", 32'h1004, {32'h0000A001, 32'h0000A000}, 1, 32'h0000A001);
        read_hit("t2ch", 32'h3004, 32'h0000C001);
        read_miss("t2b2", 32'h2000, {32'h0000B001, 32'h0000B000}, 1, 32'h0000B000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
